// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encodings and
// owner identifiers used to steer handshakes back to the I or D requester.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// arb_wait_timer: cycle counter for the in-flight transaction.
//   clr     - zero the count (grant cycle); wins over en
//   en      - count this cycle (ISSUE or WAIT)
//   count   - current registered count
//   expired - this enabled cycle is the MAX_WAIT-th one
module arb_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count,
  output logic        expired
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 16'd1;
  end

  // The current cycle is counted, so expiry fires when cnt_q+1 hits the limit.
  assign expired = en && (({1'b0, cnt_q} + 17'd1) == 17'(MAX_WAIT));
  assign count   = cnt_q;

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction
// fetch (I) and the load/store path (D), one transaction at a time.
//   i_*      - fetch read requester (request held until i_ready)
//   d_*      - load/store requester (write wins if read+write both set)
//   mem_*    - registered strobes/fields to memory, mem_ready/mem_valid back
//   timeout_error - sticky, set when a transaction is aborted
//   scan     - simulation-only state trace within the scan cycle window
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDRESS_BITS    = 20,
  parameter int NUM_BYTES       = DATA_WIDTH / 8,
  parameter int MAX_WAIT        = 255,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_read,
  input  logic [ADDRESS_BITS-1:0] i_address,
  output logic                    i_ready,
  output logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [ADDRESS_BITS-1:0] d_address,
  input  logic [NUM_BYTES-1:0]    d_byte_en,
  input  logic [DATA_WIDTH-1:0]   d_in_data,
  output logic                    d_ready,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [NUM_BYTES-1:0]    mem_byte_en,
  output logic [DATA_WIDTH-1:0]   mem_out_data,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_in_data,
  output logic                    timeout_error,
  input  logic                    scan
);

  arb_state_e              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  logic                    is_read_q, is_read_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDRESS_BITS-1:0] mem_address_q, mem_address_d;
  logic [NUM_BYTES-1:0]    mem_byte_en_q, mem_byte_en_d;
  logic [DATA_WIDTH-1:0]   mem_out_data_q, mem_out_data_d;
  logic                    i_ready_q, i_ready_d, i_valid_q, i_valid_d;
  logic                    d_ready_q, d_ready_d, d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0]   i_data_q, i_data_d, d_data_q, d_data_d;
  logic                    timeout_error_q, timeout_error_d;

  logic        timer_clr, timer_en, timer_expired;
  logic [15:0] timer_cnt;
  logic        i_req, d_req, grant_to_d;

  arb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .count   (timer_cnt),
    .expired (timer_expired)
  );

  // A requester still holds its request during its ready-pulse cycle; masking
  // it there keeps a just-finished write from being granted a second time.
  assign i_req = i_read && !i_ready_q;
  assign d_req = (d_read || d_write) && !d_ready_q;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    is_read_d       = is_read_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_byte_en_d   = mem_byte_en_q;
    mem_out_data_d  = mem_out_data_q;
    i_ready_d       = 1'b0;
    i_valid_d       = 1'b0;
    d_ready_d       = 1'b0;
    d_valid_d       = 1'b0;
    i_data_d        = i_data_q;
    d_data_d        = d_data_q;
    timeout_error_d = timeout_error_q;
    timer_clr       = 1'b0;
    timer_en        = 1'b0;
    grant_to_d      = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          // Under contention the side that did not win last time goes first.
          grant_to_d   = d_req && (!i_req || (last_grant_q == OWNER_I));
          owner_d      = grant_to_d ? OWNER_D : OWNER_I;
          last_grant_d = owner_d;
          timer_clr    = 1'b1;
          state_d      = ARB_ISSUE;
          if (grant_to_d) begin
            is_read_d      = !d_write;
            mem_read_d     = !d_write;
            mem_write_d    = d_write;
            mem_address_d  = d_address;
            mem_byte_en_d  = d_byte_en;
            mem_out_data_d = d_in_data;
          end else begin
            is_read_d      = 1'b1;
            mem_read_d     = 1'b1;
            mem_write_d    = 1'b0;
            mem_address_d  = i_address;
            mem_byte_en_d  = '1;
            mem_out_data_d = '0;
          end
        end
      end

      ARB_ISSUE: begin
        timer_en = 1'b1;
        // A real handshake in the expiry cycle still completes normally.
        if (mem_ready || timer_expired) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (owner_q == OWNER_D) d_ready_d = 1'b1;
          else                    i_ready_d = 1'b1;
          if (mem_ready) begin
            state_d = is_read_q ? ARB_WAIT : ARB_IDLE;
          end else begin
            // Abort: also hand back zero data for reads so nobody stalls.
            timeout_error_d = 1'b1;
            state_d         = ARB_IDLE;
            if (is_read_q) begin
              if (owner_q == OWNER_D) begin d_valid_d = 1'b1; d_data_d = '0; end
              else                    begin i_valid_d = 1'b1; i_data_d = '0; end
            end
          end
        end
      end

      ARB_WAIT: begin
        timer_en = 1'b1;
        // Ready was already pulsed when the strobe was accepted, so an abort
        // here only returns the zero data.
        if (mem_valid || timer_expired) begin
          state_d = ARB_IDLE;
          if (!mem_valid) timeout_error_d = 1'b1;
          if (owner_q == OWNER_D) begin
            d_valid_d = 1'b1;
            d_data_d  = mem_valid ? mem_in_data : '0;
          end else begin
            i_valid_d = 1'b1;
            i_data_d  = mem_valid ? mem_in_data : '0;
          end
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ARB_IDLE;
      owner_q         <= OWNER_I;
      last_grant_q    <= OWNER_I;
      is_read_q       <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_byte_en_q   <= '0;
      mem_out_data_q  <= '0;
      i_ready_q       <= 1'b0;
      i_valid_q       <= 1'b0;
      d_ready_q       <= 1'b0;
      d_valid_q       <= 1'b0;
      i_data_q        <= '0;
      d_data_q        <= '0;
      timeout_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      is_read_q       <= is_read_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_byte_en_q   <= mem_byte_en_d;
      mem_out_data_q  <= mem_out_data_d;
      i_ready_q       <= i_ready_d;
      i_valid_q       <= i_valid_d;
      d_ready_q       <= d_ready_d;
      d_valid_q       <= d_valid_d;
      i_data_q        <= i_data_d;
      d_data_q        <= d_data_d;
      timeout_error_q <= timeout_error_d;
    end
  end

  assign i_ready       = i_ready_q;
  assign i_valid       = i_valid_q;
  assign i_data        = i_data_q;
  assign d_ready       = d_ready_q;
  assign d_valid       = d_valid_q;
  assign d_data        = d_data_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_byte_en   = mem_byte_en_q;
  assign mem_out_data  = mem_out_data_q;
  assign timeout_error = timeout_error_q;

`ifndef SYNTHESIS
  int cyc_q;
  always_ff @(posedge clock) begin
    if (reset) cyc_q <= 0;
    else       cyc_q <= cyc_q + 1;
    if (scan && cyc_q >= SCAN_CYCLES_MIN && cyc_q <= SCAN_CYCLES_MAX)
      $display("[arb] cyc=%0d state=%s owner=%0d cnt=%0d rd=%b wr=%b",
               cyc_q, state_q.name(), owner_q, timer_cnt, mem_read_q, mem_write_q);
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int DW = 64;
  localparam int AW = 20;
  localparam int NB = 8;
  localparam int MW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_read, i_ready, i_valid;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_data;
  logic          d_read, d_write, d_ready, d_valid;
  logic [AW-1:0] d_address;
  logic [NB-1:0] d_byte_en;
  logic [DW-1:0] d_in_data, d_data;
  logic          mem_read, mem_write, mem_ready, mem_valid;
  logic [AW-1:0] mem_address;
  logic [NB-1:0] mem_byte_en;
  logic [DW-1:0] mem_out_data, mem_in_data;
  logic          timeout_error, scan;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .NUM_BYTES(NB), .MAX_WAIT(MW),
    .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
  ) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_ready(i_ready), .i_valid(i_valid), .i_data(i_data),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_byte_en(d_byte_en),
    .d_in_data(d_in_data), .d_ready(d_ready), .d_valid(d_valid), .d_data(d_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byte_en(mem_byte_en), .mem_out_data(mem_out_data), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_in_data(mem_in_data),
    .timeout_error(timeout_error), .scan(scan)
  );

  int n_cmp = 0;
  int n_err = 0;
  int c_ir, c_iv, c_dr, c_dv;
  logic prev_strb = 1'b0;
  logic [AW-1:0] grant_log[$];
  bit auto_mem = 1'b0;
  logic was_read = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  // Advance one cycle, sample 1ns after the edge, count pulses, log grants,
  // and optionally act as a memory that accepts at once and returns read
  // data (0xA0000000 + address) on the following cycle.
  task automatic tick();
    @(posedge clock); #1;
    if (i_ready) c_ir++;
    if (i_valid) c_iv++;
    if (d_ready) c_dr++;
    if (d_valid) c_dv++;
    if ((mem_read || mem_write) && !prev_strb) grant_log.push_back(mem_address);
    prev_strb = mem_read || mem_write;
    if (auto_mem) begin
      mem_valid   = was_read;
      mem_in_data = was_read ? (64'hA000_0000 + 64'(rd_addr)) : '0;
      was_read    = 1'b0;
      mem_ready   = mem_read || mem_write;
      if (mem_read) begin was_read = 1'b1; rd_addr = mem_address; end
    end
  endtask

  task automatic clr_counts();
    c_ir = 0; c_iv = 0; c_dr = 0; c_dv = 0;
  endtask

  task automatic mem_off();
    auto_mem = 1'b0; was_read = 1'b0; mem_ready = 1'b0; mem_valid = 1'b0; mem_in_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    n_cmp++; if ({mem_read, mem_write, i_ready, i_valid, d_ready, d_valid, timeout_error} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0", {mem_read, mem_write, i_ready, i_valid, d_ready, d_valid, timeout_error}); end
    n_cmp++; if ({mem_address, mem_byte_en, mem_out_data} !== '0) begin
      n_err++; $display("FAIL reset_mem_fields: got %h expected 0", {mem_address, mem_byte_en, mem_out_data}); end
    n_cmp++; if ({i_data, d_data} !== '0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", {i_data, d_data}); end
    reset = 1'b0; tick();
  endtask

  task automatic test_i_read();
    clr_counts();
    i_read = 1'b1; i_address = 20'h100;
    tick();  // first ISSUE cycle
    n_cmp++; if ({mem_read, mem_write} !== 2'b10) begin n_err++; $display("FAIL t1_strobe: got %b expected 10", {mem_read, mem_write}); end
    n_cmp++; if (mem_address !== 20'h100) begin n_err++; $display("FAIL t1_addr: got %h expected 100", mem_address); end
    n_cmp++; if (mem_byte_en !== 8'hFF) begin n_err++; $display("FAIL t1_be: got %h expected ff", mem_byte_en); end
    n_cmp++; if (mem_out_data !== 64'h0) begin n_err++; $display("FAIL t1_wdata: got %h expected 0", mem_out_data); end
    tick();
    tick();
    n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL t1_strobe_held: got %b expected 1", mem_read); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_cmp++; if ({i_ready, mem_read} !== 2'b10) begin n_err++; $display("FAIL t1_ready: got %b expected 10", {i_ready, mem_read}); end
    i_read = 1'b0;
    tick();
    tick();
    mem_valid = 1'b1; mem_in_data = 64'hDEAD;
    tick();
    mem_valid = 1'b0; mem_in_data = '0;
    n_cmp++; if (i_valid !== 1'b1 || i_data !== 64'hDEAD) begin n_err++; $display("FAIL t1_valid: got %b/%h expected 1/dead", i_valid, i_data); end
    tick();
    n_cmp++; if (i_valid !== 1'b0 || i_data !== 64'hDEAD) begin n_err++; $display("FAIL t1_hold: got %b/%h expected 0/dead", i_valid, i_data); end
    n_cmp++; if ({c_ir, c_iv, c_dr, c_dv} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL t1_pulse_counts: got ir=%0d iv=%0d dr=%0d dv=%0d expected 1 1 0 0", c_ir, c_iv, c_dr, c_dv); end
  endtask

  task automatic test_d_store();
    clr_counts();
    d_write = 1'b1; d_address = 20'h40; d_byte_en = 8'h0F; d_in_data = 64'h1234;
    tick();
    n_cmp++; if ({mem_read, mem_write} !== 2'b01) begin n_err++; $display("FAIL t2_strobe: got %b expected 01", {mem_read, mem_write}); end
    n_cmp++; if ({mem_address, mem_byte_en, mem_out_data} !== {20'h40, 8'h0F, 64'h1234}) begin
      n_err++; $display("FAIL t2_fields: got %h/%h/%h expected 40/0f/1234", mem_address, mem_byte_en, mem_out_data); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_cmp++; if ({mem_write, d_ready, d_valid} !== 3'b010) begin n_err++; $display("FAIL t2_done: got %b expected 010", {mem_write, d_ready, d_valid}); end
    d_write = 1'b0; d_byte_en = '0; d_in_data = '0;
    i_read = 1'b1; i_address = 20'h80;
    auto_mem = 1'b1;
    tick();
    n_cmp++; if (mem_read !== 1'b1 || mem_address !== 20'h80) begin
      n_err++; $display("FAIL t2_idle_next: got %b/%h expected 1/80", mem_read, mem_address); end
    for (int k = 0; k < 20 && c_iv == 0; k++) begin tick(); if (i_ready) i_read = 1'b0; end
    n_cmp++; if (c_iv !== 1 || i_data !== 64'hA000_0080) begin n_err++; $display("FAIL t2_followup: got %0d/%h expected 1/a0000080", c_iv, i_data); end
    n_cmp++; if (c_dr !== 1 || c_dv !== 0) begin n_err++; $display("FAIL t2_d_pulses: got dr=%0d dv=%0d expected 1 0", c_dr, c_dv); end
    i_read = 1'b0; tick(); mem_off();
  endtask

  task automatic test_round_robin();
    do_reset();
    clr_counts(); grant_log.delete();
    auto_mem = 1'b1;
    i_read = 1'b1; i_address = 20'h200;
    d_read = 1'b1; d_address = 20'h300;
    for (int k = 0; k < 60 && !(c_iv == 2 && c_dv == 2); k++) begin
      tick();
      if (i_ready) begin if (c_ir >= 2) i_read = 1'b0; else i_address = i_address + 20'h8; end
      if (d_ready) begin if (c_dr >= 2) d_read = 1'b0; else d_address = d_address + 20'h8; end
    end
    n_cmp++; if (grant_log.size() !== 4) begin n_err++; $display("FAIL t3_grants: got %0d expected 4", grant_log.size()); end
    if (grant_log.size() >= 4) begin
      n_cmp++; if (grant_log[0] !== 20'h300) begin n_err++; $display("FAIL t3_g0: got %h expected 300", grant_log[0]); end
      n_cmp++; if (grant_log[1] !== 20'h200) begin n_err++; $display("FAIL t3_g1: got %h expected 200", grant_log[1]); end
      n_cmp++; if (grant_log[2] !== 20'h308) begin n_err++; $display("FAIL t3_g2: got %h expected 308", grant_log[2]); end
      n_cmp++; if (grant_log[3] !== 20'h208) begin n_err++; $display("FAIL t3_g3: got %h expected 208", grant_log[3]); end
    end
    n_cmp++; if (d_data !== 64'hA000_0308 || i_data !== 64'hA000_0208) begin
      n_err++; $display("FAIL t3_data: got %h/%h expected a0000308/a0000208", d_data, i_data); end
    tick(); tick(); mem_off();
  endtask

  task automatic test_back_to_back();
    clr_counts();
    auto_mem = 1'b1;
    i_read = 1'b1; i_address = 20'h500;
    for (int k = 0; k < 10 && c_ir == 0; k++) tick();
    // i_ready cycle: read is in WAIT and the memory model drives mem_valid now.
    i_read = 1'b0;
    d_read = 1'b1; d_address = 20'h600;
    tick();
    n_cmp++; if (i_valid !== 1'b1 || mem_read !== 1'b0 || i_data !== 64'hA000_0500) begin
      n_err++; $display("FAIL t4_valid: got %b/%b/%h expected 1/0/a0000500", i_valid, mem_read, i_data); end
    tick();
    n_cmp++; if (mem_read !== 1'b1 || mem_address !== 20'h600) begin
      n_err++; $display("FAIL t4_d_strobe: got %b/%h expected 1/600", mem_read, mem_address); end
    for (int k = 0; k < 20 && c_dv == 0; k++) begin tick(); if (d_ready) d_read = 1'b0; end
    n_cmp++; if (c_dv !== 1 || d_data !== 64'hA000_0600) begin n_err++; $display("FAIL t4_d_data: got %0d/%h expected 1/a0000600", c_dv, d_data); end
    d_read = 1'b0; tick(); mem_off();
  endtask

  task automatic test_timeout();
    int strobes;
    clr_counts(); mem_off();
    strobes = 0;
    d_read = 1'b1; d_address = 20'h700;
    for (int k = 1; k <= MW; k++) begin
      tick();
      if (mem_read) strobes++;
    end
    n_cmp++; if (strobes !== MW) begin n_err++; $display("FAIL t5_issue_cycles: got %0d expected %0d", strobes, MW); end
    n_cmp++; if (timeout_error !== 1'b0 || d_ready !== 1'b0) begin n_err++; $display("FAIL t5_early: got %b/%b expected 0/0", timeout_error, d_ready); end
    tick();
    n_cmp++; if ({mem_read, d_ready, d_valid, timeout_error} !== 4'b0111) begin
      n_err++; $display("FAIL t5_abort: got %b expected 0111", {mem_read, d_ready, d_valid, timeout_error}); end
    n_cmp++; if (d_data !== 64'h0) begin n_err++; $display("FAIL t5_d_data: got %h expected 0", d_data); end
    d_read = 1'b0;
    tick();
    n_cmp++; if (timeout_error !== 1'b1 || d_ready !== 1'b0) begin n_err++; $display("FAIL t5_sticky: got %b/%b expected 1/0", timeout_error, d_ready); end
    clr_counts();
    auto_mem = 1'b1;
    i_read = 1'b1; i_address = 20'h900;
    for (int k = 0; k < 20 && c_iv == 0; k++) begin tick(); if (i_ready) i_read = 1'b0; end
    n_cmp++; if (c_ir !== 1 || c_iv !== 1 || i_data !== 64'hA000_0900) begin
      n_err++; $display("FAIL t5_recover: got %0d/%0d/%h expected 1/1/a0000900", c_ir, c_iv, i_data); end
    n_cmp++; if (timeout_error !== 1'b1) begin n_err++; $display("FAIL t5_sticky_after: got %b expected 1", timeout_error); end
    i_read = 1'b0; tick(); mem_off();
  endtask

  task automatic test_reset_in_wait();
    clr_counts(); mem_off();
    i_read = 1'b1; i_address = 20'hA00;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; i_read = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    mem_valid = 1'b1; mem_in_data = 64'hBEEF;
    tick();
    mem_valid = 1'b0; mem_in_data = '0;
    n_cmp++; if ({i_valid, d_valid, i_ready, d_ready, mem_read, mem_write, timeout_error} !== 7'b0) begin
      n_err++; $display("FAIL t6_flags: got %b expected 0", {i_valid, d_valid, i_ready, d_ready, mem_read, mem_write, timeout_error}); end
    n_cmp++; if ({i_data, d_data, mem_address} !== '0) begin n_err++; $display("FAIL t6_data: got %h expected 0", {i_data, d_data, mem_address}); end
    tick();
    n_cmp++; if (c_iv !== 1'b0 && c_iv !== 0) begin n_err++; $display("FAIL t6_no_valid: got %0d expected 0", c_iv); end
    d_read = 1'b1; d_address = 20'hB00;
    tick();
    n_cmp++; if (mem_read !== 1'b1 || mem_address !== 20'hB00) begin n_err++; $display("FAIL t6_idle: got %b/%h expected 1/b00", mem_read, mem_address); end
    auto_mem = 1'b1;
    for (int k = 0; k < 20 && c_dv == 0; k++) begin tick(); if (d_ready) d_read = 1'b0; end
    d_read = 1'b0; mem_off();
  endtask

  initial begin
    reset = 1'b0; scan = 1'b0;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_byte_en = '0; d_in_data = '0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_in_data = '0;
    clr_counts();
    test_reset();
    test_i_read();
    test_d_store();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single external memory port between instruction fetch (I side) and the data load/store path (D side).
- Sequences one outstanding transaction at a time through a small state machine.
- Gives two-way round-robin priority under contention, routes read data back to the owner, and aborts hung transactions with a timeout.
- Sits between the fetch/memory stages and the memory interface; its ready/valid outputs feed the i_mem and d_mem hazard logic.

Parameters:
- DATA_WIDTH, 64, width of the data bus.
- ADDRESS_BITS, 20, width of the byte address.
- NUM_BYTES, DATA_WIDTH/8, number of byte-enable lanes.
- MAX_WAIT, 255, cycle limit in ISSUE+WAIT before abort (range 1..65535).
- SCAN_CYCLES_MIN, 0, first cycle of scan printing.
- SCAN_CYCLES_MAX, 1000, last cycle of scan printing.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- i_read  in  1  fetch read request, held until i_ready
- i_address  in  ADDRESS_BITS  fetch address, stable while i_read
- i_ready  out  1  one-cycle pulse: I request accepted by memory
- i_valid  out  1  one-cycle pulse: i_data valid
- i_data  out  DATA_WIDTH  fetch read data
- d_read  in  1  load request
- d_write  in  1  store request
- d_address  in  ADDRESS_BITS  data address
- d_byte_en  in  NUM_BYTES  store byte enables
- d_in_data  in  DATA_WIDTH  store data
- d_ready  out  1  one-cycle pulse: D request accepted
- d_valid  out  1  one-cycle pulse: d_data valid (loads only)
- d_data  out  DATA_WIDTH  load data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDRESS_BITS  memory address
- mem_byte_en  out  NUM_BYTES  memory byte enables
- mem_out_data  out  DATA_WIDTH  memory write data
- mem_ready  in  1  memory accepts the current strobe
- mem_valid  in  1  memory read data valid
- mem_in_data  in  DATA_WIDTH  memory read data
- timeout_error  out  1  sticky abort flag
- scan  in  1  enables state printing in the scan window

Behaviour:
Reset values and interface rules
- Reset is synchronous: all outputs 0, state IDLE, owner=I, last_grant=I, wait counter 0.
- Reset mid-transaction drops it silently. mem_valid arriving after reset is ignored because the block is in IDLE.
- Requesters hold the request and its fields stable until their ready pulse. Changing them earlier is undefined.
- d_read and d_write both high is treated as a write.

States
- IDLE:
  - I only: grant I. D only: grant D.
  - Both: grant the side not equal to last_grant. After reset, D wins the first contention.
  - On grant (cycle T): register owner, last_grant, mem_read/mem_write, mem_address, mem_byte_en and mem_out_data; go to ISSUE. Strobes are visible at T+1.
  - For I grants: mem_byte_en is all ones and mem_out_data is 0.
- ISSUE:
  - Strobe is held while mem_ready is low.
  - mem_ready high at cycle U: at U+1 the owner's x_ready pulses and strobes drop.
  - Next state is WAIT if the transaction is a read, IDLE if a write. Writes produce no x_valid.
- WAIT:
  - mem_valid high at cycle V: at V+1, x_data is loaded from mem_in_data and x_valid pulses; go to IDLE.
  - A new grant can be made in cycle V+1, so its strobe appears at V+2.
- Spurious inputs: mem_valid in IDLE or ISSUE is ignored. mem_ready outside ISSUE is ignored.

Timeout
- The wait counter clears on grant and increments each cycle in ISSUE or WAIT.
- When it reaches MAX_WAIT (counted in the current cycle):
  - drop strobes and go to IDLE next cycle;
  - set timeout_error (sticky until reset);
  - pulse the owner's x_ready, and also x_valid with x_data=0 if the transaction is a read, so the pipeline cannot deadlock.

Other rules
- The non-owner's ready/valid outputs stay 0 throughout a transaction.
- The non-owner's data output holds its last value.
- Scan: when scan=1 and the cycle counter is within [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX], print the state, owner, counter and strobes (simulation only).

Decomposition:
- Shared package holds:
  - state encodings ARB_IDLE, ARB_ISSUE, ARB_WAIT (2 bits);
  - owner constants OWNER_I=0, OWNER_D=1.
- One sub-module, arb_wait_timer: a counter with clear and enable inputs and an expired flag, parameterized by MAX_WAIT.

Test Plan:
1. I-only read at 0x100. Memory gives mem_ready 2 cycles after the strobe and mem_valid 3 cycles later with 0xDEAD → exactly one i_ready pulse, then one i_valid pulse with i_data=0xDEAD; d_ready and d_valid stay 0.
2. D store at 0x40, byte_en 0x0F, data 0x1234, mem_ready in the first ISSUE cycle → mem_write=1 for one cycle with those exact fields; d_ready pulses; no d_valid; back to IDLE on the next cycle.
3. After reset, I and D read requests asserted in the same cycle and held → D granted first, then I; then, with both repeatedly requesting, grants alternate D,I,D,I.
4. Back-to-back: the next D load is asserted while the current I read is in WAIT → D strobe appears exactly 2 cycles after the mem_valid cycle of the I read.
5. Timeout: MAX_WAIT=8, D read with mem_ready never asserted → abort after 8 ISSUE cycles; timeout_error=1 and stays 1; d_ready and d_valid pulse with d_data=0; a subsequent I read completes normally.
6. Reset asserted in WAIT, then mem_valid arrives 1 cycle after reset deasserts → all outputs 0, no x_valid, state IDLE.
